// File: rtl/arb_nway_pkg.sv
// Shared types, mode constants and helpers for the N-way grant arbiter.
package arb_nway_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    localparam int unsigned ARB_MODE_FIXED = 0;
    localparam int unsigned ARB_MODE_RR    = 1;
    localparam int unsigned ARB_MAX_N      = 16;

    // Index of the set bit in a one-hot (or zero) vector of up to ARB_MAX_N bits.
    function automatic logic [3:0] onehot2idx(input logic [ARB_MAX_N-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_nway_if.sv
// Request/grant bundle between N clients (master side) and the arbiter (slave side).
interface arb_nway_if
    import arb_nway_pkg::*;
#(
    parameter int unsigned N    = 3,
    parameter int unsigned IDXW = (N > 1) ? $clog2(N) : 1
);

    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic            grant_valid;
    logic [IDXW-1:0] grant_idx;
    logic            preempt;

    modport master (
        output req,
        input  grant,
        input  grant_valid,
        input  grant_idx,
        input  preempt
    );

    modport slave (
        input  req,
        output grant,
        output grant_valid,
        output grant_idx,
        output preempt
    );

endinterface

// File: rtl/arb_nway_pick.sv
// Combinational winner select: rotate the request vector by ptr, take the lowest set bit,
// then rotate the offset back. With rr_en low the rotation is zero (fixed priority).
module arb_nway_pick
    import arb_nway_pkg::*;
#(
    parameter int unsigned N    = 3,
    parameter int unsigned IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IDXW-1:0] ptr_i,
    input  logic            rr_en_i,
    output logic            any_o,
    output logic [IDXW-1:0] idx_o,
    output logic [N-1:0]    onehot_o
);

    localparam logic [IDXW:0] NVal = (IDXW + 1)'(N);
    localparam logic [N-1:0]  One  = {{(N - 1){1'b0}}, 1'b1};

    logic [IDXW-1:0] shift;
    logic [2*N-1:0]  dbl;
    logic [N-1:0]    rot;
    logic [N-1:0]    first;
    logic [IDXW-1:0] off;
    logic [IDXW:0]   sum;

    always_comb begin
        shift = rr_en_i ? ptr_i : '0;
        dbl   = {req_i, req_i} >> shift;
        rot   = dbl[N-1:0];
        // Isolate the lowest set bit of the rotated vector.
        first = rot & (~rot + One);
        off   = IDXW'(onehot2idx(ARB_MAX_N'(first)));
        sum   = {1'b0, shift} + {1'b0, off};
        if (sum >= NVal) sum = sum - NVal;
        any_o    = |req_i;
        idx_o    = any_o ? sum[IDXW-1:0] : '0;
        onehot_o = any_o ? (One << idx_o) : '0;
    end

endmodule

// File: rtl/arb_nway.sv
// N-requester grant arbiter: fixed or round-robin priority, optional hold limit with
// preemption, zero-bubble handoff. All outputs are registered.
module arb_nway
    import arb_nway_pkg::*;
#(
    parameter int unsigned N        = 3,
    parameter int unsigned RR_MODE  = 1,
    parameter int unsigned MAX_HOLD = 0,
    parameter int unsigned IDXW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic clk,
    input  logic reset,
    arb_nway_if.slave bus
);

    localparam int unsigned     HW      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0]   HoldMax = HW'(MAX_HOLD);
    localparam logic [HW-1:0]   HoldOne = HW'(1);
    localparam logic [IDXW-1:0] LastIdx = IDXW'(N - 1);
    localparam logic            RrEn    = (RR_MODE == ARB_MODE_RR);

    arb_state_t      state_q;
    logic [N-1:0]    grant_q;
    logic            grant_valid_q;
    logic [IDXW-1:0] grant_idx_q;
    logic [IDXW-1:0] rr_ptr_q;
    logic [HW-1:0]   hold_cnt_q;
    logic            preempt_q;

    logic            full_any, oth_any;
    logic [IDXW-1:0] full_idx, oth_idx;
    logic [N-1:0]    full_oh, oth_oh;
    logic [N-1:0]    others;
    logic            owner_req;
    logic            hold_expired;
    logic            do_preempt;
    logic [IDXW-1:0] take_idx;
    logic [N-1:0]    take_oh;
    logic [IDXW-1:0] take_ptr;

    arb_nway_pick #(.N(N), .IDXW(IDXW)) u_pick_full (
        .req_i    (bus.req),
        .ptr_i    (rr_ptr_q),
        .rr_en_i  (RrEn),
        .any_o    (full_any),
        .idx_o    (full_idx),
        .onehot_o (full_oh)
    );

    arb_nway_pick #(.N(N), .IDXW(IDXW)) u_pick_oth (
        .req_i    (others),
        .ptr_i    (rr_ptr_q),
        .rr_en_i  (RrEn),
        .any_o    (oth_any),
        .idx_o    (oth_idx),
        .onehot_o (oth_oh)
    );

    always_comb begin
        others       = bus.req & ~grant_q;
        owner_req    = |(bus.req & grant_q);
        hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HoldMax);
        do_preempt   = (state_q == ARB_BUSY) && owner_req && hold_expired && oth_any;
        take_idx     = do_preempt ? oth_idx : full_idx;
        take_oh      = do_preempt ? oth_oh : full_oh;
        take_ptr     = (take_idx == LastIdx) ? '0 : take_idx + IDXW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            rr_ptr_q      <= '0;
            hold_cnt_q    <= '0;
            preempt_q     <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            if (state_q == ARB_BUSY && owner_req && !hold_expired) begin
                if (MAX_HOLD != 0) hold_cnt_q <= hold_cnt_q + HoldOne;
            end else if (state_q == ARB_BUSY && owner_req && !oth_any) begin
                // Limit reached but nobody else waiting: restart the hold window.
                hold_cnt_q <= HoldOne;
            end else if (do_preempt || full_any) begin
                // New grant from IDLE, preemption, or direct handoff on release.
                state_q       <= ARB_BUSY;
                grant_q       <= take_oh;
                grant_valid_q <= 1'b1;
                grant_idx_q   <= take_idx;
                rr_ptr_q      <= take_ptr;
                hold_cnt_q    <= HoldOne;
                preempt_q     <= do_preempt;
            end else begin
                state_q       <= ARB_IDLE;
                grant_q       <= '0;
                grant_valid_q <= 1'b0;
                grant_idx_q   <= '0;
                hold_cnt_q    <= '0;
            end
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.preempt     = preempt_q;

endmodule

// File: tb/tb_arb_nway.sv
// Scoreboard bench for arb_nway: four configurations share one clock and reset; stimulus
// queues expected outputs per cycle, a monitor pops and compares after each edge.
module tb_arb_nway;
    import arb_nway_pkg::*;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;

    typedef struct {
        int          cyc;
        int          dut;
        logic [15:0] g;
        logic [3:0]  idx;
        logic        pre;
        string       tag;
    } exp_t;

    exp_t sb[$];

    arb_nway_if #(.N(3)) ifa ();
    arb_nway_if #(.N(4)) ifb ();
    arb_nway_if #(.N(3)) ifc ();
    arb_nway_if #(.N(4)) ifd ();

    arb_nway #(.N(3), .RR_MODE(1), .MAX_HOLD(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    arb_nway #(.N(4), .RR_MODE(0), .MAX_HOLD(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
    arb_nway #(.N(3), .RR_MODE(1), .MAX_HOLD(4)) dut_c (.clk(clk), .reset(reset), .bus(ifc));
    arb_nway #(.N(4), .RR_MODE(1), .MAX_HOLD(1)) dut_d (.clk(clk), .reset(reset), .bus(ifd));

    logic [15:0] g_w   [4];
    logic [3:0]  i_w   [4];
    logic        v_w   [4];
    logic        p_w   [4];
    logic [15:0] req_w [4];
    logic [15:0] req_edge [4];

    assign g_w[0] = 16'(ifa.grant);  assign i_w[0] = 4'(ifa.grant_idx);
    assign g_w[1] = 16'(ifb.grant);  assign i_w[1] = 4'(ifb.grant_idx);
    assign g_w[2] = 16'(ifc.grant);  assign i_w[2] = 4'(ifc.grant_idx);
    assign g_w[3] = 16'(ifd.grant);  assign i_w[3] = 4'(ifd.grant_idx);
    assign v_w[0] = ifa.grant_valid; assign p_w[0] = ifa.preempt;
    assign v_w[1] = ifb.grant_valid; assign p_w[1] = ifb.preempt;
    assign v_w[2] = ifc.grant_valid; assign p_w[2] = ifc.preempt;
    assign v_w[3] = ifd.grant_valid; assign p_w[3] = ifd.preempt;
    assign req_w[0] = 16'(ifa.req);
    assign req_w[1] = 16'(ifb.req);
    assign req_w[2] = 16'(ifc.req);
    assign req_w[3] = 16'(ifd.req);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 4; d++) req_edge[d] <= req_w[d];
    end

    // Expected outputs for the edge following the current negedge.
    task automatic expect_g(input int dut, input logic [15:0] g, input int idx,
                            input logic pre, input string tag);
        exp_t e;
        e.cyc = cyc + 1;
        e.dut = dut;
        e.g   = g;
        e.idx = 4'(idx);
        e.pre = pre;
        e.tag = tag;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc || g_w[e.dut] !== e.g || i_w[e.dut] !== e.idx ||
                v_w[e.dut] !== (|e.g) || p_w[e.dut] !== e.pre) begin
                failures++;
                $display("FAIL %s dut=%0d cyc=%0d: got grant=%h idx=%0d valid=%b preempt=%b, required grant=%h idx=%0d valid=%b preempt=%b at cyc=%0d",
                         e.tag, e.dut, cyc, g_w[e.dut], i_w[e.dut], v_w[e.dut], p_w[e.dut],
                         e.g, e.idx, |e.g, e.pre, e.cyc);
            end
        end
        if (cyc > 1) begin
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (!$onehot0(g_w[d]) || (g_w[d] & ~req_edge[d]) != 16'h0 ||
                    v_w[d] !== (|g_w[d])) begin
                    failures++;
                    $display("FAIL invariant dut=%0d cyc=%0d: got grant=%h valid=%b, required one-hot within req=%h",
                             d, cyc, g_w[d], v_w[d], req_edge[d]);
                end
            end
        end
    end

    initial begin
        cyc      = 0;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        ifa.req  = 3'b111;
        ifb.req  = '0;
        ifc.req  = '0;
        ifd.req  = '0;

        // Reset with requests held: no grant until one edge after reset is released.
        repeat (2) begin
            @(negedge clk);
            expect_g(0, 16'h0, 0, 1'b0, "reset_hold");
        end
        @(negedge clk);
        reset = 1'b0;
        expect_g(0, 16'h1, 0, 1'b0, "first_grant");

        // Zero-bubble handoff in RR mode.
        repeat (2) begin
            @(negedge clk);
            expect_g(0, 16'h1, 0, 1'b0, "hold_owner0");
        end
        @(negedge clk); ifa.req = 3'b110; expect_g(0, 16'h2, 1, 1'b0, "handoff_to1");
        @(negedge clk);                   expect_g(0, 16'h2, 1, 1'b0, "hold_owner1");
        @(negedge clk); ifa.req = 3'b100; expect_g(0, 16'h4, 2, 1'b0, "handoff_to2");
        @(negedge clk);                   expect_g(0, 16'h4, 2, 1'b0, "hold_owner2");

        // Fixed priority, N=4.
        @(negedge clk); ifb.req = 4'b1010; expect_g(1, 16'h2, 1, 1'b0, "fixed_1010");
        @(negedge clk);                    expect_g(1, 16'h2, 1, 1'b0, "fixed_hold");
        @(negedge clk); ifb.req = 4'b1001; expect_g(1, 16'h1, 0, 1'b0, "fixed_1001");
        @(negedge clk); ifb.req = 4'b1000; expect_g(1, 16'h8, 3, 1'b0, "fixed_1000");
        @(negedge clk); ifb.req = 4'b0000; expect_g(1, 16'h0, 0, 1'b0, "fixed_idle");

        // Hold limit 4 with a competitor, then alone.
        @(negedge clk); ifc.req = 3'b011; expect_g(2, 16'h1, 0, 1'b0, "hold_g0");
        repeat (3) begin
            @(negedge clk);
            expect_g(2, 16'h1, 0, 1'b0, "hold_g0");
        end
        @(negedge clk);                   expect_g(2, 16'h2, 1, 1'b1, "preempt_move");
        @(negedge clk);                   expect_g(2, 16'h2, 1, 1'b0, "preempt_single");
        @(negedge clk); ifc.req = 3'b000; expect_g(2, 16'h0, 0, 1'b0, "preempt_release");
        @(negedge clk); ifc.req = 3'b001; expect_g(2, 16'h1, 0, 1'b0, "alone_grant");
        repeat (10) begin
            @(negedge clk);
            expect_g(2, 16'h1, 0, 1'b0, "alone_no_preempt");
        end
        @(negedge clk); ifc.req = 3'b000; expect_g(2, 16'h0, 0, 1'b0, "alone_release");

        // Round-robin rotation with a one-cycle hold limit.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) ifd.req = 4'hf;
            expect_g(3, 16'h1 << (i % 4), i % 4, (i != 0), "rr_rotate");
        end
        @(negedge clk); ifd.req = 4'h0; expect_g(3, 16'h0, 0, 1'b0, "rr_release");

        // Reset while owner 2 holds, then while owner 0 holds (rr_ptr=1 before reset).
        @(negedge clk); reset = 1'b1; ifa.req = 3'b111; expect_g(0, 16'h0, 0, 1'b0, "midrst_drop");
        @(negedge clk); reset = 1'b0; expect_g(0, 16'h1, 0, 1'b0, "midrst_restart");
        @(negedge clk);               expect_g(0, 16'h1, 0, 1'b0, "midrst_hold");
        @(negedge clk); reset = 1'b1; expect_g(0, 16'h0, 0, 1'b0, "midrst2_drop");
        @(negedge clk); reset = 1'b0; expect_g(0, 16'h1, 0, 1'b0, "midrst_ptr_cleared");
        @(negedge clk); ifa.req = 3'b000; expect_g(0, 16'h0, 0, 1'b0, "final_idle");

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
